serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
// Bit-serial N-bit adder controller. Sequences one internal 1-bit full-adder
// cell (sum = A^B^C, carry = majority(A,B,C)) over N clock cycles, LSB first.
// Operands are captured on a start handshake. Sum and carry-out are delivered
// with a one-cycle done pulse. Used where area matters more than latency: the
// single full-adder cell is time-shared across all bit positions.
//
// PARAMETERS
// N         8   operand / result width in bits (N >= 2)
// CNT_W     $clog2(N+1)   bit-counter width (derived; not to be overridden)
//
// PORTS
// clk      in   1  system clock, rising-edge
// rst_n    in   1  reset, synchronous, active-low
// start    in   1  request: capture operands and begin an addition
// a        in   N  operand A (sampled only when start is accepted)
// b        in   N  operand B (sampled only when start is accepted)
// cin      in   1  carry-in (sampled only when start is accepted)
// busy     out  1  high while an addition is in progress (state RUN)
// done     out  1  one-cycle pulse: sum/cout valid
// sum      out  N  result, registered
// cout     out  1  carry-out of MSB, registered
//
// BEHAVIOUR
// - One clock. Reset is synchronous and active-low. When rst_n=0 at a rising
//   edge: state=IDLE; busy=0, done=0, sum=0, cout=0; counter and shift regs=0.
// - FSM states: IDLE, RUN, FIN.
//   IDLE: start=1 -> latch a, b and cin into the shift regs A_sr, B_sr and
//         the carry reg; counter=0; go to RUN.
//   RUN:  each cycle, the full adder processes A_sr[0], B_sr[0] and carry.
//         The result bit shifts into R_sr from the MSB side (right shift).
//         A_sr and B_sr shift right. The new carry is registered.
//         counter++. When counter reaches N-1 in this cycle, go to FIN next.
//   FIN:  sum<=R_sr, cout<=carry, done=1 for this single cycle.
//         start=1 here is accepted (same as IDLE) -> RUN; else -> IDLE.
// - busy=1 exactly in RUN. The start input is ignored in RUN: no restart and
//   no operand change.
// - Latency: start sampled at edge k -> RUN for edges k+1..k+N -> done=1 in
//   the cycle after edge k+N. Back-to-back throughput is one result per N+1
//   cycles.
// - sum/cout update only on entry to FIN. They hold their value until the next
//   completion, including through IDLE and RUN.
// - Width rules: arithmetic is modulo 2^N. The carry out of bit N-1 is cout.
//   There is no signed overflow output.
// - Reset mid-RUN: the operation is abandoned; no done pulse; outputs return to
//   their reset values.
// - The a, b and cin inputs may change freely after the accepting edge.
//
// CONFIGURATION
// SERIAL_ADDER_SUB_EN
//   defined:   adds input port sub (1 bit, sampled with start). If sub=1, the
//              latched B is ~b and the latched carry is 1 (cin ignored), so
//              sum = a - b mod 2^N and cout = 1 means no borrow. sub=0 behaves
//              as plain addition.
//   undefined: no sub port; add only.
//
// TESTING (N=8)
// 1. a=8'h5A, b=8'h33, cin=0, start 1 cycle -> busy for 8 cycles;
//    done in the 9th cycle after the start edge; sum=8'h8D, cout=0.
// 2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//    a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
// 3. Assert start again (new a/b) while busy -> ignored. The first result is
//    unchanged and exactly one done pulse occurs.
// 4. start held high continuously -> a done pulse every 9 cycles. Each result
//    uses the operands present at its accepting edge.
// 5. rst_n=0 on the 4th RUN cycle -> next edge: busy=0, sum=0, cout=0, no done.
//    A following start completes normally.
// 6. SERIAL_ADDER_SUB_EN defined: a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, cout=1.
//    a=8'h01, b=8'h02, sub=1 -> sum=8'hFF, cout=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if
// Handshake and data bundle for the bit-serial adder controller.
// Optional macro: SERIAL_ADDER_SUB_EN adds the 'sub' request bit.
//   master: drives start, a, b, cin (and sub); observes busy, done, sum, cout
//   slave : the adder controller side
interface serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial N-bit adder: one shared full-adder cell is stepped over the
// operand bits LSB first, one bit per clock. The result and carry-out are
// registered and announced with a single-cycle done pulse.
// Optional macro: SERIAL_ADDER_SUB_EN enables subtraction (a - b) via bus.sub.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_adder_if.slave (start/a/b/cin[/sub] in, busy/done/sum/cout out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit processed per cycle
// FIN   | sum/cout valid, done high; start may launch the next operation
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] a_sr, b_sr, r_sr;
    logic         carry;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0] sum_q;
    logic         cout_q;

    logic         accept;
    logic         busy_c, done_c;
    logic         last_bit;
    logic         fa_sum, fa_carry;
    logic [N-1:0] b_load;
    logic         c_load;

    // Subtraction is two's complement: invert b and force the carry-in.
    always_comb begin
        b_load = bus.b;
        c_load = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (bus.sub) begin
            b_load = ~bus.b;
            c_load = 1'b1;
        end
`endif
    end

    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_bit) state_next = FIN;
            end
            FIN: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= b_load;
            r_sr  <= '0;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= {1'b0, a_sr[N-1:1]};
            b_sr  <= {1'b0, b_sr[N-1:1]};
            r_sr  <= {fa_sum, r_sr[N-1:1]};
            carry <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
            // Final bit goes straight into the result register so sum is
            // valid in the same cycle done rises.
            if (last_bit) begin
                sum_q  <= {fa_sum, r_sr[N-1:1]};
                cout_q <= fa_carry;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sub_in = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.N(N)) bus ();
    serial_adder_ctrl #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub = sub_in;
`endif

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    endfunction

    // Model: counts remaining busy cycles; result computed arithmetically.
    int           m_left = 0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0;
    logic [N-1:0] m_sum = '0;
    logic [N:0]   m_pend = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) {m_cout, m_sum} = m_pend;
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_left = N;
                m_pend = ref_result(bus.a, bus.b, bus.cin, sub_in);
            end
        end
        m_busy = (m_left > 0);
        #1;
        check("cyc_busy", (N+1)'(bus.busy), (N+1)'(m_busy));
        check("cyc_done", (N+1)'(bus.done), (N+1)'(m_done));
        check("cyc_sum",  (N+1)'(bus.sum),  (N+1)'(m_sum));
        check("cyc_cout", (N+1)'(bus.cout), (N+1)'(m_cout));
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input logic sub, input logic [N-1:0] exp_sum, input logic exp_cout);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; sub_in = sub;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = N'($urandom); bus.b = N'($urandom); bus.cin = 1'($urandom);
        sub_in = 1'($urandom);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", (N+1)'(n), (N+1)'(N));
        check("lit_sum", (N+1)'(bus.sum), (N+1)'(exp_sum));
        check("lit_cout", (N+1)'(bus.cout), (N+1)'(exp_cout));
    endtask

    initial begin
        int dones;
        logic [N-1:0] seen_sum;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", (N+1)'(bus.busy), '0);
        check("rst_done", (N+1)'(bus.done), '0);
        check("rst_sum",  (N+1)'(bus.sum),  '0);
        check("rst_cout", (N+1)'(bus.cout), '0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

        // Restart attempt while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; sub_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        dones = 0; seen_sum = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) begin dones++; seen_sum = bus.sum; end
        end
        check("busy_ignore_dones", (N+1)'(dones), (N+1)'(1));
        check("busy_ignore_sum", (N+1)'(seen_sum), (N+1)'(8'h46));

        // Start held high: one result every N+1 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h21; bus.b = 8'h43; bus.cin = 1'b1;
        dones = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            bus.a = N'($urandom); bus.b = N'($urandom); bus.cin = 1'($urandom);
        end
        bus.start = 1'b0;
        check("held_start_dones", (N+1)'(dones), (N+1)'(3));

        run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

        // Reset on the 4th RUN cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0; sub_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", (N+1)'(bus.busy), '0);
        check("midrst_done", (N+1)'(bus.done), '0);
        check("midrst_sum",  (N+1)'(bus.sum),  '0);
        check("midrst_cout", (N+1)'(bus.cout), '0);
        rst_n = 1'b1;
        run_op(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
